// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and pad-block helper for the SHA-3 absorb-block assembler.
package sha3_pkg;

  localparam int DATA_W    = 16;
  localparam int RATE_BITS = 1088;
  localparam int WORDS     = RATE_BITS / DATA_W;
  localparam int IDX_W     = $clog2(WORDS);

  localparam logic [DATA_W-1:0] PAD_WORD   = 16'h0003;
  localparam logic [3:0]        PAD_NIBBLE = 4'h3;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PADW = 2'd1,
    EMIT = 2'd2
  } blk_state_t;

  // Block carrying only the trailing pad: word0 = pad nibble, final pad bit in the MSB.
  function automatic logic [RATE_BITS-1:0] pad_only_block();
    logic [RATE_BITS-1:0] b;
    b                = '0;
    b[DATA_W-1:0]    = {{(DATA_W-4){1'b0}}, PAD_NIBBLE};
    b[RATE_BITS-1]   = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/sha3_block_asm.sv
// Packs padded 16-bit stream words into one rate-wide block for the Keccak core, one block at a time.
// Optional sticky illegal-tuser flag blk_err is built only when SHA3_BLK_ERR_EN is defined.
module sha3_block_asm
  import sha3_pkg::*;
(
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [3:0]           s_axis_tuser,
  output logic [RATE_BITS-1:0] blk_data,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 blk_last
`ifdef SHA3_BLK_ERR_EN
  ,
  output logic                 blk_err
`endif
);

  blk_state_t           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [RATE_BITS-1:0] r_blk;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_pad_pend;

  logic                 w_hs_in;
  logic                 w_full;
  logic                 w_at_end;
  logic                 w_pad_deferred;
  logic [IDX_W-1:0]     w_idx_nx;
  logic [RATE_BITS-1:0] w_fill_blk;

  assign s_axis_tready = (r_state == FILL);
  assign w_hs_in       = s_axis_tvalid && s_axis_tready;

  // tuser 5..15 is treated exactly like a full final word.
  assign w_full         = (s_axis_tuser >= 4'd4);
  assign w_at_end       = (r_idx == IDX_W'(WORDS - 1));
  assign w_pad_deferred = s_axis_tlast && w_full && w_at_end;
  assign w_idx_nx       = r_idx + 1'b1;

  always_comb begin
    w_fill_blk = r_blk;
    w_fill_blk[r_idx*DATA_W +: DATA_W] = s_axis_tdata;
    if (s_axis_tlast && !w_pad_deferred) begin
      if (w_full) begin
        w_fill_blk[w_idx_nx*DATA_W +: DATA_W] = PAD_WORD;
      end
      w_fill_blk[RATE_BITS-1] = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= FILL;
      r_idx      <= '0;
      r_blk      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_pad_pend <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_hs_in) begin
            r_blk <= w_fill_blk;
            if (s_axis_tlast || w_at_end) begin
              r_state    <= EMIT;
              r_valid    <= 1'b1;
              r_last     <= s_axis_tlast && !w_pad_deferred;
              r_pad_pend <= w_pad_deferred;
            end else begin
              r_idx <= w_idx_nx;
            end
          end
        end
        PADW: begin
          r_blk      <= pad_only_block();
          r_last     <= 1'b1;
          r_valid    <= 1'b1;
          r_pad_pend <= 1'b0;
          r_state    <= EMIT;
        end
        EMIT: begin
          if (blk_ready) begin
            r_blk   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= r_pad_pend ? PADW : FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign blk_data  = r_blk;
  assign blk_valid = r_valid;
  assign blk_last  = r_last;

`ifdef SHA3_BLK_ERR_EN
  logic r_err;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_err <= 1'b0;
    end else if (w_hs_in && s_axis_tlast && (s_axis_tuser > 4'd4)) begin
      r_err <= 1'b1;
    end
  end

  assign blk_err = r_err;
`endif

endmodule
